// File: rtl/lsu_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
//   size_e  : access size encoding carried on req_size
//   err_e   : response error code carried on rsp_err
//   state_e : LSU sequencing states
//   check_req() : classifies a request at accept time
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_RANGE    = 2'd2,
        ERR_SIZE     = 2'd3
    } err_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCESS  = 3'd1,
        CAPTURE = 3'd2,
        MERGE   = 3'd3,
        RESP    = 3'd4
    } state_e;

    // Error priority: illegal size, then misalignment, then word index range.
    function automatic err_e check_req(input logic [31:0] addr, input size_e size,
                                       input int unsigned depth);
        if (size == SZ_ILL)
            return ERR_SIZE;
        if ((size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00))
            return ERR_MISALIGN;
        if ({2'b00, addr[31:2]} >= depth)
            return ERR_RANGE;
        return ERR_OK;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Request/response handshake between the execute stage and the LSU.
//   master : requester (drives req_*, rsp_ready)
//   slave  : LSU       (drives req_ready, rsp_*)
interface lsu_mem_stage_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    modport master (
        output req_valid, req_addr, req_wdata, req_we, req_size, req_unsigned, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, req_size, req_unsigned, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane handling for the LSU.
//   addr_lo     : byte offset within the word
//   size        : access size
//   is_unsigned : zero-extend (1) or sign-extend (0) sub-word loads
//   mem_word    : word read from memory
//   wdata       : right-justified store data (only the low half is ever used)
//   load_data   : extracted and extended load result
//   merge_data  : mem_word with the target lane replaced by store data
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  size_e       size,
    input  logic        is_unsigned,
    input  logic [31:0] mem_word,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v     = mem_word[{addr_lo, 3'b000} +: 8];
        half_v     = mem_word[{addr_lo[1], 4'b0000} +: 16];
        load_data  = '0;
        merge_data = mem_word;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{byte_v[7] & ~is_unsigned}}, byte_v};
                merge_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{half_v[15] & ~is_unsigned}}, half_v};
                merge_data[{addr_lo[1], 4'b0000} +: 16] = wdata;
            end
            SZ_WORD: load_data = mem_word;
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit in front of a word-addressed data memory
// without byte enables. Sub-word stores are done as read-modify-write.
//   clk, rst_n  : clock, synchronous active-low reset
//   bus         : request/response handshake (slave side)
//   mem_address : word index, zero-extended
//   mem_in      : write data to memory
//   mem_en      : memory enable
//   mem_r_w     : 0=read, 1=write
//   mem_out     : memory read data, valid the cycle after a read
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter  int unsigned DEPTH = 2048,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lsu_mem_stage_if.slave       bus,
    output logic [31:0]          mem_address,
    output logic [31:0]          mem_in,
    output logic                 mem_en,
    output logic                 mem_r_w,
    input  logic [31:0]          mem_out
);

    state_e            state;
    // Address bits above the word index are only needed for the range check
    // at accept, so they are not held.
    logic [IDX_W+1:0]  addr_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    size_e             size_q;
    logic              uns_q;
    logic [31:0]       rdata_q;
    err_e              err_q;

    err_e              req_err;
    logic              word_store;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;

    assign req_err    = check_req(bus.req_addr, size_e'(bus.req_size), DEPTH);
    assign word_store = we_q && (size_q == SZ_WORD);

    lsu_lane_align u_align (
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .mem_word    (mem_out),
        .wdata       (wdata_q[15:0]),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr[IDX_W+1:0];
                        wdata_q <= bus.req_wdata;
                        we_q    <= bus.req_we;
                        size_q  <= size_e'(bus.req_size);
                        uns_q   <= bus.req_unsigned;
                        rdata_q <= '0;
                        err_q   <= req_err;
                        state   <= (req_err == ERR_OK) ? ACCESS : RESP;
                    end
                end
                ACCESS: begin
                    if (word_store)
                        state <= RESP;
                    else if (we_q)
                        state <= MERGE;
                    else
                        state <= CAPTURE;
                end
                CAPTURE: begin
                    rdata_q <= load_data;
                    state   <= RESP;
                end
                MERGE: state <= RESP;
                RESP: begin
                    if (bus.rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    assign mem_address = 32'(addr_q[IDX_W+1:2]);

    // Reset gating is combinational so an in-flight write is squashed in the
    // very cycle reset is asserted.
    always_comb begin
        mem_en  = 1'b0;
        mem_r_w = 1'b0;
        mem_in  = '0;
        case (state)
            ACCESS: begin
                mem_en  = 1'b1;
                mem_r_w = word_store;
                mem_in  = wdata_q;
            end
            MERGE: begin
                mem_en  = 1'b1;
                mem_r_w = 1'b1;
                mem_in  = merge_data;
            end
            default: ;
        endcase
        if (!rst_n) begin
            mem_en  = 1'b0;
            mem_r_w = 1'b0;
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a synchronous-read data memory model.
module tb_lsu_mem_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_address;
    logic [31:0] mem_in;
    logic        mem_en;
    logic        mem_r_w;
    logic [31:0] mem_out;
    logic [31:0] mem [2048];

    int checks = 0;
    int errors = 0;

    lsu_mem_stage_if bus ();

    lsu_mem_stage #(.DEPTH(2048)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .mem_address (mem_address),
        .mem_in      (mem_in),
        .mem_en      (mem_en),
        .mem_r_w     (mem_r_w),
        .mem_out     (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_r_w)
                mem[mem_address[10:0]] <= mem_in;
            else
                mem_out <= mem[mem_address[10:0]];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    // Present a request at the current negedge; returns one negedge after the accept edge.
    task automatic drive_req(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic we, input logic [1:0] size, input logic uns);
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_valid    = 1'b1;
        check_eq("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] exp);
        drive_req(addr, 32'h0, 1'b0, size, uns);
        check_eq({tag, "_t1_en"}, 32'(mem_en), 32'd1);
        check_eq({tag, "_t1_rw"}, 32'(mem_r_w), 32'd0);
        check_eq({tag, "_t1_idx"}, mem_address, 32'd6);
        @(negedge clk);
        check_eq({tag, "_t2_en"}, 32'(mem_en), 32'd0);
        check_eq({tag, "_t2_valid"}, 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check_eq({tag, "_t3_valid"}, 32'(bus.rsp_valid), 32'd1);
        check_eq({tag, "_rdata"}, bus.rsp_rdata, exp);
        check_eq({tag, "_err"}, 32'(bus.rsp_err), 32'd0);
        @(negedge clk);
        check_eq({tag, "_idle"}, 32'(bus.req_ready), 32'd1);
    endtask

    task automatic do_err(input string tag, input logic [31:0] addr, input logic we,
                          input logic [1:0] size, input logic [1:0] exp_err);
        drive_req(addr, 32'hDEADBEEF, we, size, 1'b0);
        check_eq({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        check_eq({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
        check_eq({tag, "_rdata"}, bus.rsp_rdata, 32'h0);
        check_eq({tag, "_en_t1"}, 32'(mem_en), 32'd0);
        @(negedge clk);
        check_eq({tag, "_idle"}, 32'(bus.req_ready), 32'd1);
        check_eq({tag, "_en_t2"}, 32'(mem_en), 32'd0);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.rsp_ready    = 1'b1;

        repeat (2) @(negedge clk);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check_eq("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check_eq("rst_mem_en", 32'(mem_en), 32'd0);
        check_eq("rst_mem_rw", 32'(mem_r_w), 32'd0);
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Word store 0x12345678 -> 0x18 (index 6)
        drive_req(32'h18, 32'h12345678, 1'b1, 2'd2, 1'b0);
        check_eq("wst_en", 32'(mem_en), 32'd1);
        check_eq("wst_rw", 32'(mem_r_w), 32'd1);
        check_eq("wst_idx", mem_address, 32'd6);
        check_eq("wst_in", mem_in, 32'h12345678);
        check_eq("wst_t1_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check_eq("wst_valid", 32'(bus.rsp_valid), 32'd1);
        check_eq("wst_err", 32'(bus.rsp_err), 32'd0);
        check_eq("wst_rdata", bus.rsp_rdata, 32'h0);
        check_eq("wst_t2_en", 32'(mem_en), 32'd0);
        @(negedge clk);
        check_eq("wst_idle", 32'(bus.req_ready), 32'd1);
        check_eq("wst_mem6", mem[6], 32'h12345678);

        // Byte store 0x80 -> 0x19, upper wdata bits must be ignored
        drive_req(32'h19, 32'hAAAAAA80, 1'b1, 2'd0, 1'b0);
        check_eq("bst_t1_en", 32'(mem_en), 32'd1);
        check_eq("bst_t1_rw", 32'(mem_r_w), 32'd0);
        check_eq("bst_t1_idx", mem_address, 32'd6);
        @(negedge clk);
        check_eq("bst_t2_en", 32'(mem_en), 32'd1);
        check_eq("bst_t2_rw", 32'(mem_r_w), 32'd1);
        check_eq("bst_t2_idx", mem_address, 32'd6);
        check_eq("bst_t2_in", mem_in, 32'h12348078);
        check_eq("bst_t2_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check_eq("bst_valid", 32'(bus.rsp_valid), 32'd1);
        check_eq("bst_err", 32'(bus.rsp_err), 32'd0);
        check_eq("bst_rdata", bus.rsp_rdata, 32'h0);
        @(negedge clk);
        check_eq("bst_mem6", mem[6], 32'h12348078);

        // Loads from word 6 = 0x12348078
        do_load("lh_s_18", 32'h18, 2'd1, 1'b0, 32'hFFFF8078);
        do_load("lb_u_1b", 32'h1B, 2'd0, 1'b1, 32'h00000012);
        do_load("lh_u_18", 32'h18, 2'd1, 1'b1, 32'h00008078);
        do_load("lb_s_19", 32'h19, 2'd0, 1'b0, 32'hFFFFFF80);
        do_load("lh_s_1a", 32'h1A, 2'd1, 1'b0, 32'h00001234);
        do_load("lw_18", 32'h18, 2'd2, 1'b0, 32'h12348078);

        // Error responses
        do_err("err_mis_word", 32'h1A, 1'b0, 2'd2, 2'd1);
        do_err("err_range", 32'h2000, 1'b0, 2'd1, 2'd2);
        do_err("err_size", 32'h1A, 1'b0, 2'd3, 2'd3);
        do_err("err_mis_over_range", 32'h2001, 1'b0, 2'd1, 2'd1);
        do_err("err_range_store", 32'h2000, 1'b1, 2'd2, 2'd2);

        // Response backpressure; a competing store is offered and must be ignored
        bus.rsp_ready = 1'b0;
        drive_req(32'h18, 32'h0, 1'b0, 2'd2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_eq("stall_valid0", 32'(bus.rsp_valid), 32'd1);
        check_eq("stall_rdata0", bus.rsp_rdata, 32'h12348078);
        bus.req_addr  = 32'h18;
        bus.req_wdata = 32'h0;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'd2;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stall_valid", 32'(bus.rsp_valid), 32'd1);
            check_eq("stall_rdata", bus.rsp_rdata, 32'h12348078);
            check_eq("stall_err", 32'(bus.rsp_err), 32'd0);
            check_eq("stall_req_ready", 32'(bus.req_ready), 32'd0);
            check_eq("stall_en", 32'(mem_en), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_eq("stall_release_idle", 32'(bus.req_ready), 32'd1);
        check_eq("stall_release_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("stall_mem6", mem[6], 32'h12348078);

        // Reset in MERGE of a byte store must squash the write
        drive_req(32'h18, 32'h00000055, 1'b1, 2'd0, 1'b0);
        check_eq("rstm_t1_en", 32'(mem_en), 32'd1);
        check_eq("rstm_t1_rw", 32'(mem_r_w), 32'd0);
        @(negedge clk);
        check_eq("rstm_merge_rw", 32'(mem_r_w), 32'd1);
        check_eq("rstm_merge_in", mem_in, 32'h12348055);
        rst_n = 1'b0;
        #1;
        check_eq("rstm_gated_en", 32'(mem_en), 32'd0);
        check_eq("rstm_gated_rw", 32'(mem_r_w), 32'd0);
        @(negedge clk);
        check_eq("rstm_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rstm_rsp_rdata", bus.rsp_rdata, 32'h0);
        check_eq("rstm_rsp_err", 32'(bus.rsp_err), 32'd0);
        check_eq("rstm_req_ready", 32'(bus.req_ready), 32'd1);
        check_eq("rstm_en", 32'(mem_en), 32'd0);
        check_eq("rstm_mem6", mem[6], 32'h12348078);
        rst_n = 1'b1;
        @(negedge clk);
        do_load("rstm_readback", 32'h18, 2'd2, 1'b0, 32'h12348078);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Memory-stage load/store unit sitting directly upstream of the data memory.
- Accepts byte-addressed load/store requests from the execute stage over a valid/ready handshake.
- Converts byte addresses to the word index the data memory uses.
- Performs read-modify-write for byte/halfword stores, since the memory has no byte enables; sign/zero-extends load data; returns one response per request.

Parameters:
- DEPTH, 2048, number of 32-bit words in the data memory.
- IDX_W, $clog2(DEPTH), word-index width (derived, not overridden).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  2  0=ok, 1=misaligned, 2=out of range, 3=illegal size
- mem_address  out  32  word index, zero-extended from IDX_W
- mem_in  out  32  write data to memory
- mem_en  out  1  memory enable
- mem_r_w  out  1  0=read, 1=write
- mem_out  in  32  memory read data; valid the cycle after a read-enabled cycle

Behaviour:
- Reset (rst_n low at edge):
  - State=IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Latched request registers cleared.
  - mem_en and mem_r_w are gated to 0 combinationally whenever rst_n=0.
  - A reset in any state aborts the operation; no memory write occurs in or after that cycle.
- Handshake:
  - req_ready=1 only in IDLE.
  - A request is accepted on the edge where req_valid&&req_ready; addr, wdata, we, size and unsigned are latched.
  - rsp_valid holds, with rsp_rdata/rsp_err stable, until rsp_ready=1; then the FSM returns to IDLE. No new request is accepted in the RESP cycle.
- Error check at accept (priority: illegal size > misaligned > out of range):
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Out of range: addr[31:2] >= DEPTH.
  - On error: go to RESP with rsp_err set, rsp_rdata=0; mem_en never asserted.
- Memory outputs: combinational from state and latched regs.
  - mem_address = addr[IDX_W+1:2].
  - mem_en=0 and mem_r_w=0 outside ACCESS/MERGE.
- FSM states and transitions:
  - IDLE -> ACCESS, or -> RESP on error.
  - ACCESS:
    - mem_en=1.
    - Word store: mem_r_w=1, mem_in=wdata -> RESP.
    - Load or sub-word store: mem_r_w=0 -> CAPTURE (load) or MERGE (sub-word store).
  - CAPTURE: mem_en=0; extract the lane from mem_out, extend, register into rsp_rdata -> RESP.
  - MERGE: mem_en=1, mem_r_w=1, mem_in = mem_out with the target lane replaced -> RESP.
  - RESP: wait for rsp_ready -> IDLE.
- Latency from accept edge T:
  - Error: rsp_valid at T+1.
  - Word store: T+2.
  - Load and sub-word store: T+3.
- Lanes (little-endian):
  - Byte lane = addr[1:0], bits [8*addr[1:0]+7 : 8*addr[1:0]].
  - Half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
  - Store data uses wdata[7:0] / wdata[15:0]; upper wdata bits ignored.
  - Sign extension from the lane MSB when req_unsigned=0.
  - Word loads ignore req_unsigned.

Decomposition:
- Package lsu_pkg:
  - size_e (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL)
  - err_e (ERR_OK, ERR_MISALIGN, ERR_RANGE, ERR_SIZE)
  - state_e (IDLE, ACCESS, CAPTURE, MERGE, RESP)
- Sub-module lsu_lane_align: purely combinational; load extract/extend and store lane merge. Instantiated once; the FSM and handshake stay in the top module.

Test Plan:
- Word store 0x12345678 to 0x18, rsp_ready=1 -> mem write index 6 at T+1; rsp_valid at T+2, err 0, rdata 0.
- Then byte store 0x80 to 0x19 -> read index 6 at T+1, write 0x12348078 at T+2, rsp at T+3.
- Then signed half load 0x18 -> 0xFFFF8078 at T+3; unsigned byte load 0x1B -> 0x00000012; unsigned half load 0x18 -> 0x00008078.
- Word load 0x1A -> err 1 at T+1; half load 0x2000 -> err 2; size 3 -> err 3; mem_en stays 0 throughout.
- Load with rsp_ready low 3 cycles -> rsp_valid/rdata stable, req_ready 0 throughout, IDLE one cycle after rsp_ready rises.
- Byte store with rst_n low during MERGE -> mem_en 0 that cycle; word 6 unchanged on readback; all outputs at reset values.
